// File: rtl/axi4_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi4_burst_addr_gen
//
// Sits downstream of the read side of the command AsyncFIFO. It takes one
// AW/AR command per S_VALID/S_READY handshake and expands it into LEN+1 beat
// descriptors: ID, beat address, beat index, LAST and an error flag. Beat
// addresses follow the AXI4 FIXED / INCR / WRAP rules. Illegal commands
// still produce LEN+1 beats, at a held address, with M_ERR set on every beat.
//
// Ports
//   CLK, RESETn         : clock (rising edge), async active-low reset
//   S_ID/ADDR/LEN/SIZE/BURST, S_VALID, S_READY
//                       : command input (FIFO RDATA / RVALID / RREADY)
//   M_ID/ADDR/BEAT/LAST/ERR, M_VALID, M_READY
//                       : beat descriptor output
// ----------------------------------------------------------------------------
module axi4_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_SIZE   = 2
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ID_WIDTH-1:0]   S_ID,
    input  logic [ADDR_WIDTH-1:0] S_ADDR,
    input  logic [7:0]            S_LEN,
    input  logic [2:0]            S_SIZE,
    input  logic [1:0]            S_BURST,
    input  logic                  S_VALID,
    output logic                  S_READY,
    output logic [ID_WIDTH-1:0]   M_ID,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    output logic [7:0]            M_BEAT,
    output logic                  M_LAST,
    output logic                  M_ERR,
    output logic                  M_VALID,
    input  logic                  M_READY
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    // Latched burst shape; burst is forced to FIXED for illegal commands.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd;

    logic                  load, beat_hs;
    logic                  s_err, len_ok;
    logic [ADDR_WIDTH-1:0] s_step;
    logic [ADDR_WIDTH-1:0] step, aligned, incr, wrap_mask, next_addr;

    assign M_VALID = (state == BURST);
    assign beat_hs = M_VALID & M_READY;
    assign load    = S_VALID & S_READY;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (load)                  state_nxt = BURST;
        else if (beat_hs && M_LAST) state_nxt = IDLE;
    end

    // ---------------- output logic ----------------
    // Ready on the final accepted beat lets the next burst follow with no
    // bubble. Nothing here depends on S_VALID.
    always_comb begin
        S_READY = (state == IDLE) | (beat_hs & M_LAST);
    end

    // ---------------- command legality ----------------
    always_comb begin
        s_step = ONE << S_SIZE;
        len_ok = (S_LEN == 8'd1) || (S_LEN == 8'd3) || (S_LEN == 8'd7) || (S_LEN == 8'd15);
        s_err  = (S_BURST == 2'b11)
               | (32'(S_SIZE) > 32'(MAX_SIZE))
               | ((S_BURST == BT_WRAP) & (!len_ok | (|(S_ADDR & (s_step - ONE)))));
    end

    // ---------------- next beat address ----------------
    always_comb begin
        step      = ONE << cmd.size;
        aligned   = M_ADDR & ~(step - ONE);
        incr      = aligned + step;
        // Wrap container size is (LEN+1) << SIZE; LEN is a power of two minus
        // one for any legal WRAP, so the container is a clean mask.
        wrap_mask = ((ADDR_WIDTH'(cmd.len) + ONE) << cmd.size) - ONE;
        case (cmd.burst)
            BT_INCR: next_addr = incr;
            BT_WRAP: next_addr = (M_ADDR & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr = M_ADDR;
        endcase
    end

    // ---------------- beat datapath ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cmd    <= '0;
            M_ID   <= '0;
            M_ADDR <= '0;
            M_BEAT <= '0;
            M_LAST <= 1'b0;
            M_ERR  <= 1'b0;
        end else if (load) begin
            cmd.len   <= S_LEN;
            cmd.size  <= S_SIZE;
            cmd.burst <= s_err ? BT_FIXED : S_BURST;
            M_ID      <= S_ID;
            M_ADDR    <= S_ADDR;
            M_BEAT    <= 8'd0;
            M_LAST    <= (S_LEN == 8'd0);
            M_ERR     <= s_err;
        end else if (beat_hs && !M_LAST) begin
            M_ADDR <= next_addr;
            M_BEAT <= M_BEAT + 8'd1;
            M_LAST <= ((M_BEAT + 8'd1) == cmd.len);
        end
    end

endmodule
